dp_ram_clr: RTL and testbench

// Single-clock, true dual-port block RAM. Successor to our plain dual-port RAM, adding:
// - per-byte write enables
// - selectable read-during-write mode
// - defined same-address collision priority
// - optional output pipeline register with valid flags
// - hardware bulk-clear engine

---
 rtl/dp_ram_clr_pkg.sv | 25 ++
 rtl/dp_ram_clr_port.sv | 93 +++++++++
 rtl/dp_ram_clr.sv | 142 ++++++++++++++
 tb/tb_dp_ram_clr.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_ram_clr_pkg.sv
// dp_ram_clr_pkg
// Shared types and helpers for the dual-port clearable RAM.
//   clr_state_e      : bulk-clear engine state
//   RDW_WRITE_FIRST  : same-port read-during-write returns the merged word
//   RDW_READ_FIRST   : same-port read-during-write returns the old word
//   be_merge()       : merges one byte lane; callers loop it across the word
package dp_ram_clr_pkg;

  typedef enum logic {
    CLR_IDLE = 1'b0,
    CLR_RUN  = 1'b1
  } clr_state_e;

  localparam int RDW_WRITE_FIRST = 0;
  localparam int RDW_READ_FIRST  = 1;

  // Kept lane-sized so it works for any DATA without width padding; the
  // callers apply it once per byte lane to build the merged word.
  function automatic logic [7:0] be_merge(input logic [7:0] old_lane,
                                          input logic [7:0] new_lane,
                                          input logic       be);
    return be ? new_lane : old_lane;
  endfunction

endpackage

// File: rtl/dp_ram_clr_port.sv
// dp_ram_clr_port
// Read-side pipeline for one RAM port: read-during-write data selection,
// optional output register and the matching valid pipeline.
//   clk, rst_n : clock and asynchronous active-low reset
//   acc        : access accepted this cycle
//   be_w       : lanes this access writes (zero for reads)
//   din        : write data of this access
//   rd_word    : registered array word for the access accepted last cycle
//   dout, vld  : read data and its valid flag
module dp_ram_clr_port
  import dp_ram_clr_pkg::*;
#(
  parameter int DATA     = 8,
  parameter int RDW_MODE = 0,
  parameter int OUT_REG  = 0,
  parameter int BE_W     = DATA / 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            acc,
  input  logic [BE_W-1:0] be_w,
  input  logic [DATA-1:0] din,
  input  logic [DATA-1:0] rd_word,
  output logic [DATA-1:0] dout,
  output logic            vld
);

  localparam logic WRITE_FIRST = (RDW_MODE == RDW_WRITE_FIRST);

  logic            acc_q;
  logic [BE_W-1:0] be_q;
  logic [DATA-1:0] din_q;
  logic [DATA-1:0] hold_q;
  logic [DATA-1:0] rd_data;

  // Remember the write lanes and data of the accepted access so the merge
  // lines up with the array word that arrives one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= 1'b0;
      be_q  <= '0;
      din_q <= '0;
    end else begin
      acc_q <= acc;
      if (acc) begin
        be_q  <= be_w;
        din_q <= din;
      end
    end
  end

  // Write-first overlays the freshly written lanes on the old word;
  // read-first passes the old word untouched.
  always_comb begin
    rd_data = rd_word;
    for (int i = 0; i < BE_W; i++) begin
      rd_data[8*i +: 8] = be_merge(rd_word[8*i +: 8], din_q[8*i +: 8],
                                   be_q[i] & WRITE_FIRST);
    end
  end

  // Last delivered word: keeps dout stable on idle cycles, and doubles as
  // the output register when the extra pipeline stage is enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else if (acc_q) begin
      hold_q <= rd_data;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic vld_q;

      // Second valid stage tracks the registered output word.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q <= 1'b0;
        end else begin
          vld_q <= acc_q;
        end
      end

      assign dout = hold_q;
      assign vld  = vld_q;
    end else begin : g_no_out_reg
      assign dout = acc_q ? rd_data : hold_q;
      assign vld  = acc_q;
    end
  endgenerate

endmodule

// File: rtl/dp_ram_clr.sv
// dp_ram_clr
// Single-clock true dual-port RAM with byte enables, selectable
// read-during-write, A-wins collision masking, optional output register
// and a bulk-clear engine that writes CLR_VAL two words per cycle.
//   clk, rst_n          : clock and asynchronous active-low reset
//   clr_req / clr_busy  : start a bulk clear / clear engine owns both ports
//   a_en, a_wr, a_be    : port A enable, write, byte enables
//   a_addr, a_din       : port A address and write data
//   a_dout, a_vld       : port A read data and valid
//   b_*                 : port B, same set as port A
module dp_ram_clr
  import dp_ram_clr_pkg::*;
#(
  parameter int              DATA     = 8,
  parameter int              ADDR     = 10,
  parameter int              RDW_MODE = 0,
  parameter int              OUT_REG  = 0,
  parameter logic [DATA-1:0] CLR_VAL  = '0,
  localparam int             BE_W     = DATA / 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr_req,
  output logic            clr_busy,
  input  logic            a_en,
  input  logic            a_wr,
  input  logic [BE_W-1:0] a_be,
  input  logic [ADDR-1:0] a_addr,
  input  logic [DATA-1:0] a_din,
  output logic [DATA-1:0] a_dout,
  output logic            a_vld,
  input  logic            b_en,
  input  logic            b_wr,
  input  logic [BE_W-1:0] b_be,
  input  logic [ADDR-1:0] b_addr,
  input  logic [DATA-1:0] b_din,
  output logic [DATA-1:0] b_dout,
  output logic            b_vld
);

  localparam int              DEPTH     = 2 ** ADDR;
  localparam logic [ADDR-1:0] LAST_PAIR = ADDR'(DEPTH - 2);

  logic [DATA-1:0] mem [DEPTH];

  clr_state_e      state;
  clr_state_e      state_nxt;
  logic [ADDR-1:0] ptr;

  logic            a_acc;
  logic            b_acc;
  logic [BE_W-1:0] a_be_w;
  logic [BE_W-1:0] b_be_w;
  logic [BE_W-1:0] a_lane_we;
  logic [BE_W-1:0] b_lane_we;
  logic [ADDR-1:0] a_waddr;
  logic [ADDR-1:0] b_waddr;
  logic [DATA-1:0] a_wdata;
  logic [DATA-1:0] b_wdata;
  logic [DATA-1:0] a_rd_q;
  logic [DATA-1:0] b_rd_q;

  // Clear state and pointer. The pointer only returns to zero through the
  // terminal pair, never by overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLR_IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLR_RUN) begin
        ptr <= (ptr == LAST_PAIR) ? '0 : ptr + ADDR'(2);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLR_IDLE: if (clr_req) state_nxt = CLR_RUN;
      CLR_RUN:  if (ptr == LAST_PAIR) state_nxt = CLR_IDLE;
      default:  state_nxt = CLR_IDLE;
    endcase
  end

  always_comb begin
    clr_busy = (state == CLR_RUN);
  end

  // Port write lanes, or the clear engine's two writes while it runs.
  // On a same-address double write, B keeps only the lanes A leaves alone.
  always_comb begin
    a_acc  = a_en && (state == CLR_IDLE);
    b_acc  = b_en && (state == CLR_IDLE);
    a_be_w = a_wr ? a_be : '0;
    b_be_w = b_wr ? b_be : '0;
    if (state == CLR_RUN) begin
      a_lane_we = '1;
      b_lane_we = '1;
      a_waddr   = ptr;
      b_waddr   = ptr + ADDR'(1);
      a_wdata   = CLR_VAL;
      b_wdata   = CLR_VAL;
    end else begin
      a_lane_we = a_acc ? a_be_w : '0;
      b_lane_we = b_acc ? b_be_w : '0;
      if (a_addr == b_addr) begin
        b_lane_we = b_lane_we & ~a_lane_we;
      end
      a_waddr = a_addr;
      b_waddr = b_addr;
      a_wdata = a_din;
      b_wdata = b_din;
    end
  end

  // Array reads always see the pre-write word; the port pipelines apply
  // write-first merging where selected.
  always_ff @(posedge clk) begin
    if (a_acc) a_rd_q <= mem[a_addr];
    if (b_acc) b_rd_q <= mem[b_addr];
    for (int i = 0; i < BE_W; i++) begin
      if (a_lane_we[i]) mem[a_waddr][8*i +: 8] <= a_wdata[8*i +: 8];
      if (b_lane_we[i]) mem[b_waddr][8*i +: 8] <= b_wdata[8*i +: 8];
    end
  end

  dp_ram_clr_port #(
    .DATA(DATA), .RDW_MODE(RDW_MODE), .OUT_REG(OUT_REG), .BE_W(BE_W)
  ) u_port_a (
    .clk(clk), .rst_n(rst_n), .acc(a_acc), .be_w(a_be_w), .din(a_din),
    .rd_word(a_rd_q), .dout(a_dout), .vld(a_vld)
  );

  dp_ram_clr_port #(
    .DATA(DATA), .RDW_MODE(RDW_MODE), .OUT_REG(OUT_REG), .BE_W(BE_W)
  ) u_port_b (
    .clk(clk), .rst_n(rst_n), .acc(b_acc), .be_w(b_be_w), .din(b_din),
    .rd_word(b_rd_q), .dout(b_dout), .vld(b_vld)
  );

endmodule

// File: tb/tb_dp_ram_clr.sv
// tb_dp_ram_clr
// Directed bench for dp_ram_clr. Two instances share all inputs:
//   dut0 : DATA=16, ADDR=4, write-first, latency 1, CLR_VAL=0x005A
//   dut1 : DATA=16, ADDR=4, read-first,  latency 2, CLR_VAL=0x005A
// Expected words come from a small shadow array kept by the bench.
module tb_dp_ram_clr;

  logic        clk;
  logic        rst_n;
  logic        clr_req;
  logic        a_en, a_wr, b_en, b_wr;
  logic [1:0]  a_be, b_be;
  logic [3:0]  a_addr, b_addr;
  logic [15:0] a_din, b_din;

  logic [15:0] a_dout0, b_dout0, a_dout1, b_dout1;
  logic        a_vld0, b_vld0, a_vld1, b_vld1, busy0, busy1;

  logic [15:0] model [16];
  int          vectors;
  int          miscompares;

  localparam logic [15:0] CV = 16'h005A;

  dp_ram_clr #(.DATA(16), .ADDR(4), .RDW_MODE(0), .OUT_REG(0), .CLR_VAL(CV)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .clr_busy(busy0),
    .a_en(a_en), .a_wr(a_wr), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
    .a_dout(a_dout0), .a_vld(a_vld0),
    .b_en(b_en), .b_wr(b_wr), .b_be(b_be), .b_addr(b_addr), .b_din(b_din),
    .b_dout(b_dout0), .b_vld(b_vld0)
  );

  dp_ram_clr #(.DATA(16), .ADDR(4), .RDW_MODE(1), .OUT_REG(1), .CLR_VAL(CV)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .clr_busy(busy1),
    .a_en(a_en), .a_wr(a_wr), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
    .a_dout(a_dout1), .a_vld(a_vld1),
    .b_en(b_en), .b_wr(b_wr), .b_be(b_be), .b_addr(b_addr), .b_din(b_din),
    .b_dout(b_dout1), .b_vld(b_vld1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One clock with the current inputs; outputs are then sampled 1 ns later.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic setA(input logic en, input logic wr, input logic [1:0] be,
                      input logic [3:0] addr, input logic [15:0] din);
    a_en = en; a_wr = wr; a_be = be; a_addr = addr; a_din = din;
  endtask

  task automatic setB(input logic en, input logic wr, input logic [1:0] be,
                      input logic [3:0] addr, input logic [15:0] din);
    b_en = en; b_wr = wr; b_be = be; b_addr = addr; b_din = din;
  endtask

  task automatic idleAll();
    setA(1'b0, 1'b0, 2'b00, 4'd0, 16'h0000);
    setB(1'b0, 1'b0, 2'b00, 4'd0, 16'h0000);
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, " a_dout0"}, a_dout0, 16'h0000);
    checkOutput({tag, " b_dout0"}, b_dout0, 16'h0000);
    checkOutput({tag, " a_dout1"}, a_dout1, 16'h0000);
    checkOutput({tag, " b_dout1"}, b_dout1, 16'h0000);
    checkOutput({tag, " a_vld0"}, {15'd0, a_vld0}, 16'd0);
    checkOutput({tag, " b_vld0"}, {15'd0, b_vld0}, 16'd0);
    checkOutput({tag, " a_vld1"}, {15'd0, a_vld1}, 16'd0);
    checkOutput({tag, " b_vld1"}, {15'd0, b_vld1}, 16'd0);
    checkOutput({tag, " busy0"}, {15'd0, busy0}, 16'd0);
    checkOutput({tag, " busy1"}, {15'd0, busy1}, 16'd0);
  endtask

  task automatic setModel(input logic [15:0] val);
    for (int i = 0; i < 16; i++) model[i] = val;
  endtask

  // Pulse clr_req, optionally hammer both ports while busy, count busy cycles.
  task automatic runClear(input string tag, input logic drive);
    int n;
    clr_req = 1'b1;
    applyStimulus();
    clr_req = 1'b0;
    if (drive) begin
      setA(1'b1, 1'b1, 2'b11, 4'd2, 16'h1234);
      setB(1'b1, 1'b1, 2'b11, 4'd7, 16'h4321);
    end
    n = 0;
    while (busy0 === 1'b1 && n < 40) begin
      checkOutput($sformatf("%s busy1 c%0d", tag, n), {15'd0, busy1}, 16'd1);
      checkOutput($sformatf("%s a_vld0 c%0d", tag, n), {15'd0, a_vld0}, 16'd0);
      checkOutput($sformatf("%s b_vld0 c%0d", tag, n), {15'd0, b_vld0}, 16'd0);
      checkOutput($sformatf("%s a_vld1 c%0d", tag, n), {15'd0, a_vld1}, 16'd0);
      checkOutput($sformatf("%s b_vld1 c%0d", tag, n), {15'd0, b_vld1}, 16'd0);
      n++;
      applyStimulus();
    end
    idleAll();
    checkOutput({tag, " busy cycles"}, 16'(n), 16'd8);
    checkOutput({tag, " busy1 end"}, {15'd0, busy1}, 16'd0);
  endtask

  // Back-to-back reads: A walks 0..15, B walks 15..0. dut1 lags by one.
  task automatic readSweep(input string tag);
    for (int k = 0; k < 16; k++) begin
      setA(1'b1, 1'b0, 2'b00, 4'(k), 16'h0000);
      setB(1'b1, 1'b0, 2'b00, 4'(15 - k), 16'h0000);
      applyStimulus();
      checkOutput($sformatf("%s a_dout0 k%0d", tag, k), a_dout0, model[k]);
      checkOutput($sformatf("%s b_dout0 k%0d", tag, k), b_dout0, model[15-k]);
      checkOutput($sformatf("%s a_vld0 k%0d", tag, k), {15'd0, a_vld0}, 16'd1);
      if (k == 0) begin
        checkOutput({tag, " b_vld1 first"}, {15'd0, b_vld1}, 16'd0);
      end else begin
        checkOutput($sformatf("%s a_dout1 k%0d", tag, k), a_dout1, model[k-1]);
        checkOutput($sformatf("%s b_dout1 k%0d", tag, k), b_dout1, model[16-k]);
        checkOutput($sformatf("%s b_vld1 k%0d", tag, k), {15'd0, b_vld1}, 16'd1);
      end
    end
    idleAll();
    applyStimulus();
    checkOutput({tag, " a_vld0 idle"}, {15'd0, a_vld0}, 16'd0);
    checkOutput({tag, " a_dout0 hold"}, a_dout0, model[15]);
    checkOutput({tag, " a_dout1 last"}, a_dout1, model[15]);
    checkOutput({tag, " b_dout1 last"}, b_dout1, model[0]);
    checkOutput({tag, " b_vld1 last"}, {15'd0, b_vld1}, 16'd1);
    applyStimulus();
    checkOutput({tag, " b_vld1 idle"}, {15'd0, b_vld1}, 16'd0);
    checkOutput({tag, " b_dout1 hold"}, b_dout1, model[0]);
  endtask

  // Full-word writes over the whole array; dut0 echoes new data, dut1 old.
  task automatic fillAll(input logic [15:0] val);
    logic [15:0] prev_a, prev_b;
    prev_a = '0;
    prev_b = '0;
    for (int k = 0; k < 8; k++) begin
      setA(1'b1, 1'b1, 2'b11, 4'(2 * k), val);
      setB(1'b1, 1'b1, 2'b11, 4'(2 * k + 1), val);
      applyStimulus();
      checkOutput($sformatf("fill a_dout0 k%0d", k), a_dout0, val);
      checkOutput($sformatf("fill b_dout0 k%0d", k), b_dout0, val);
      if (k > 0) begin
        checkOutput($sformatf("fill a_dout1 k%0d", k), a_dout1, prev_a);
        checkOutput($sformatf("fill b_dout1 k%0d", k), b_dout1, prev_b);
      end
      prev_a = model[2*k];
      prev_b = model[2*k+1];
      model[2*k]   = val;
      model[2*k+1] = val;
    end
    idleAll();
    applyStimulus();
    checkOutput("fill a_dout1 last", a_dout1, prev_a);
    checkOutput("fill b_dout1 last", b_dout1, prev_b);
    applyStimulus();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    clr_req     = 1'b0;
    idleAll();
    setModel(16'h0000);

    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      a_en = 1'($urandom); a_wr = 1'($urandom); a_be = 2'($urandom);
      a_addr = 4'($urandom); a_din = 16'($urandom);
      b_en = 1'($urandom); b_wr = 1'($urandom); b_be = 2'($urandom);
      b_addr = 4'($urandom); b_din = 16'($urandom);
      clr_req = 1'($urandom);
      applyStimulus();
      checkQuiet($sformatf("reset%0d", i));
    end
    idleAll();
    clr_req = 1'b0;
    rst_n   = 1'b1;
    applyStimulus();
    checkQuiet("post-reset");

    // First clear gives a known array, then read it all back
    runClear("clr0", 1'b0);
    setModel(CV);
    readSweep("sweep0");

    // Fill with 0xFFFF, clear while both ports try to write
    fillAll(16'hFFFF);
    runClear("clr1", 1'b1);
    setModel(CV);
    readSweep("sweep1");

    // Byte-lane writes to address 5
    setA(1'b1, 1'b1, 2'b11, 4'd5, 16'hBEEF);
    applyStimulus();
    checkOutput("bw full a_dout0", a_dout0, 16'hBEEF);
    checkOutput("bw full a_vld0", {15'd0, a_vld0}, 16'd1);
    idleAll();
    applyStimulus();
    checkOutput("bw full a_dout1", a_dout1, CV);
    checkOutput("bw full a_vld1", {15'd0, a_vld1}, 16'd1);
    checkOutput("bw full a_vld0 off", {15'd0, a_vld0}, 16'd0);

    setA(1'b1, 1'b1, 2'b10, 4'd5, 16'h1234);
    applyStimulus();
    checkOutput("bw hi a_dout0", a_dout0, 16'h12EF);
    idleAll();
    applyStimulus();
    checkOutput("bw hi a_dout1", a_dout1, 16'hBEEF);

    setA(1'b1, 1'b1, 2'b00, 4'd5, 16'h9999);
    applyStimulus();
    checkOutput("bw none a_dout0", a_dout0, 16'h12EF);
    idleAll();
    applyStimulus();
    checkOutput("bw none a_dout1", a_dout1, 16'h12EF);

    setB(1'b1, 1'b0, 2'b00, 4'd5, 16'h0000);
    applyStimulus();
    checkOutput("bw rd b_dout0", b_dout0, 16'h12EF);
    idleAll();
    applyStimulus();
    checkOutput("bw rd b_dout1", b_dout1, 16'h12EF);
    model[5] = 16'h12EF;

    // Same-address double write at 9: A owns the high lane
    setA(1'b1, 1'b1, 2'b10, 4'd9, 16'hAA00);
    setB(1'b1, 1'b1, 2'b11, 4'd9, 16'h3355);
    applyStimulus();
    checkOutput("coll a_dout0", a_dout0, 16'hAA5A);
    checkOutput("coll b_dout0", b_dout0, 16'h3355);
    idleAll();
    applyStimulus();
    checkOutput("coll a_dout1", a_dout1, CV);
    checkOutput("coll b_dout1", b_dout1, CV);
    model[9] = 16'hAA55;

    // Cross-port: B reads address 3 while A writes it
    setA(1'b1, 1'b1, 2'b11, 4'd3, 16'h7777);
    setB(1'b1, 1'b0, 2'b00, 4'd3, 16'h0000);
    applyStimulus();
    checkOutput("xport a_dout0", a_dout0, 16'h7777);
    checkOutput("xport b_dout0", b_dout0, CV);
    idleAll();
    applyStimulus();
    checkOutput("xport a_dout1", a_dout1, CV);
    checkOutput("xport b_dout1", b_dout1, CV);
    model[3] = 16'h7777;
    readSweep("sweep2");

    // Reset after three clear cycles: pairs 0..5 cleared, rest untouched
    fillAll(16'hFFFF);
    clr_req = 1'b1;
    applyStimulus();
    clr_req = 1'b0;
    applyStimulus();
    applyStimulus();
    applyStimulus();
    checkOutput("midclr busy0 before", {15'd0, busy0}, 16'd1);
    rst_n = 1'b0;
    #1;
    checkQuiet("midclr reset");
    applyStimulus();
    rst_n = 1'b1;
    applyStimulus();
    checkOutput("midclr busy0 after", {15'd0, busy0}, 16'd0);
    for (int i = 0; i < 6; i++) model[i] = CV;
    readSweep("sweep3");

    // A fresh clear still runs to completion
    runClear("clr2", 1'b0);
    setModel(CV);
    readSweep("sweep4");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
